// File: rtl/cipher_seq.sv
// Round-based add-rotate-xor sequencer over a 2R/1W register file; done fires ROUNDS+3 cycles after start.
// No backpressure: start is only honoured in IDLE and is dropped, not queued, while busy.
module cipher_seq #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 2,
  parameter int ROUNDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] key_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [ADDR_W-1:0] rd0_addr,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [WIDTH-1:0]  rd0_data,
  input  logic [WIDTH-1:0]  rd1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] LAST_R = 4'(ROUNDS - 1);

  logic [2:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d, key_q, key_d, dst_q, dst_d;
  logic [WIDTH-1:0]  d_q, d_d, k_q, k_d;
  logic [3:0]        r_q, r_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [WIDTH-1:0]  wd_q, wd_d;

  logic [3:0]        idx;
  logic [WIDTH-1:0]  k_i, enc_x, enc_out, dec_y, dec_out, round_out;

  // Decrypt walks the round keys in reverse so it undoes encrypt round by round.
  always_comb begin
    idx       = mode_q ? (LAST_R - r_q) : r_q;
    k_i       = k_q + WIDTH'(idx);
    enc_x     = d_q ^ k_i;
    enc_out   = {enc_x[WIDTH-2:0], enc_x[WIDTH-1]} + k_i;
    dec_y     = d_q - k_i;
    dec_out   = {dec_y[0], dec_y[WIDTH-1:1]} ^ k_i;
    round_out = mode_q ? dec_out : enc_out;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    key_d   = key_q;
    dst_d   = dst_q;
    d_d     = d_q;
    k_d     = k_q;
    r_d     = r_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          key_d   = key_addr;
          dst_d   = dst_addr;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        d_d     = rd0_data;
        k_d     = rd1_data;
        r_d     = 4'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        d_d = round_out;
        if (r_q == LAST_R) begin
          // Write port registers are loaded here so they hold between operations.
          wa_d    = dst_q;
          wd_d    = round_out;
          state_d = S_WRITE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      key_q   <= '0;
      dst_q   <= '0;
      d_q     <= '0;
      k_q     <= '0;
      r_q     <= 4'd0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      key_q   <= key_d;
      dst_q   <= dst_d;
      d_q     <= d_d;
      k_q     <= k_d;
      r_q     <= r_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  // Decoded straight from state so an asynchronous reset drops wr_en at once.
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_en    = (state_q == S_WRITE);
  assign wr_addr  = wa_q;
  assign wr_data  = wd_q;
  assign rd0_addr = busy ? src_q : '0;
  assign rd1_addr = busy ? key_q : '0;

endmodule

// File: tb/tb_cipher_seq.sv
// Directed bench for cipher_seq with a 4x9 register file model; a ROUNDS=1 copy shares the inputs.
module tb_cipher_seq;

  logic       clk, rst, start, mode;
  logic [1:0] src, key, dst;
  logic [1:0] rd0_addr, rd1_addr, wr_addr;
  logic [8:0] rd0_data, rd1_data, wr_data;
  logic       wr_en, busy, done;

  logic [1:0] rd0_addr1, rd1_addr1, wr_addr1;
  logic [8:0] rd0_data1, rd1_data1, wr_data1;
  logic       wr_en1, busy1, done1;

  logic [8:0] rf [4];
  logic       tb_we;
  logic [1:0] tb_wa;
  logic [8:0] tb_wd;
  int         wr_cnt = 0;
  logic [8:0] d1_val = '0;
  logic [1:0] d1_addr = '0;
  int         checks = 0;
  int         errors = 0;

  cipher_seq #(.WIDTH(9), .ADDR_W(2), .ROUNDS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src), .key_addr(key), .dst_addr(dst),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  cipher_seq #(.WIDTH(9), .ADDR_W(2), .ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src), .key_addr(key), .dst_addr(dst),
    .rd0_addr(rd0_addr1), .rd1_addr(rd1_addr1),
    .rd0_data(rd0_data1), .rd1_data(rd1_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1)
  );

  assign rd0_data  = rf[rd0_addr];
  assign rd1_data  = rf[rd1_addr];
  assign rd0_data1 = rf[rd0_addr1];
  assign rd1_data1 = rf[rd1_addr1];

  always @(posedge clk) begin
    if (wr_en) begin
      rf[wr_addr] <= wr_data;
      wr_cnt      <= wr_cnt + 1;
    end else if (tb_we) begin
      rf[tb_wa] <= tb_wd;
    end
    if (wr_en1) begin
      d1_val  <= wr_data1;
      d1_addr <= wr_addr1;
    end
  end

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_reg(input logic [1:0] a, input logic [8:0] v);
    tb_wa = a;
    tb_wd = v;
    tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 of the first IDLE cycle after done.
  task automatic run_op(input logic m, input logic [1:0] s, input logic [1:0] k,
                        input logic [1:0] d, input logic [8:0] exp_val, input logic poke);
    int w0;
    w0    = wr_cnt;
    mode  = m;
    src   = s;
    key   = k;
    dst   = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      if (poke && cyc >= 2 && cyc <= 4) begin
        start = 1'b1;
        mode  = ~m;
        src   = s + 2'd1;
        key   = k + 2'd2;
        dst   = d + 2'd1;
      end else begin
        start = 1'b0;
      end
      chk("busy", busy, 1);
      chk("wr_en", wr_en, (cyc == 6));
      chk("done", done, (cyc == 7));
      if (cyc == 6) begin
        chk("wr_addr", wr_addr, d);
        chk("wr_data", wr_data, exp_val);
      end
      if (cyc >= 2) begin
        chk("rd0_addr", rd0_addr, s);
        chk("rd1_addr", rd1_addr, k);
      end
      if (cyc == 7) chk("readback", rf[d], exp_val);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_rd0", rd0_addr, 0);
    chk("wr_data_hold", wr_data, exp_val);
    chk("one_write", wr_cnt, w0 + 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    src   = 2'd0;
    key   = 2'd0;
    dst   = 2'd0;
    tb_we = 1'b0;
    tb_wa = 2'd0;
    tb_wd = 9'd0;
    #2 start = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd0", rd0_addr, 0);
    chk("rst_rd1", rd1_addr, 0);
    chk("rst_busy1", {busy1, done1}, 0);
    #1 start = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("start_in_rst_ignored", busy, 0);

    load_reg(2'd0, 9'd92);
    load_reg(2'd1, 9'd65);
    load_reg(2'd2, 9'd0);
    load_reg(2'd3, 9'd0);

    // Encrypt 92 with key 65: 123, 180, 49, 302 after each round.
    run_op(1'b0, 2'd0, 2'd1, 2'd2, 9'd302, 1'b0);
    chk("rounds1_enc", d1_val, 123);
    chk("rounds1_addr", d1_addr, 2);
    // Back-to-back decrypt restores the plaintext.
    run_op(1'b1, 2'd2, 2'd1, 2'd3, 9'd92, 1'b0);

    // Key 511: round keys 511, 0, 1, 2 give 310, 109, 217, 440.
    load_reg(2'd0, 9'd100);
    load_reg(2'd1, 9'd511);
    run_op(1'b0, 2'd0, 2'd1, 2'd0, 9'd440, 1'b0);
    run_op(1'b1, 2'd0, 2'd1, 2'd0, 9'd100, 1'b0);

    // Start pulses during ROUND must be ignored.
    load_reg(2'd1, 9'd65);
    run_op(1'b0, 2'd3, 2'd1, 2'd2, 9'd302, 1'b1);
    chk("poke_no_side_write", rf[3], 92);

    // Reset during ROUND.
    begin
      int w0;
      w0 = wr_cnt;
      mode = 1'b0; src = 2'd0; key = 2'd1; dst = 2'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd0", rd0_addr, 0);
      @(negedge clk) rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_write", wr_cnt, w0);
      chk("midrst_rf", rf[3], 92);
    end

    // Reset in the WRITE cycle.
    begin
      int w0;
      w0 = wr_cnt;
      mode = 1'b0; src = 2'd0; key = 2'd1; dst = 2'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("wrrst_in_write", wr_en, 1);
      rst = 1'b1;
      #1;
      chk("wrrst_wr_en_async", wr_en, 0);
      chk("wrrst_busy", busy, 0);
      chk("wrrst_wr_data", wr_data, 0);
      @(negedge clk) rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("wrrst_no_write", wr_cnt, w0);
      chk("wrrst_rf", rf[3], 92);
    end

    run_op(1'b0, 2'd3, 2'd1, 2'd3, 9'd302, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
